mash_cfg_ctrl: RTL

Configuration sequencer for the three-stage MASH delta-sigma modulator. It accepts a new configuration over a valid/ready handshake into a shadow register: three 8-bit level words, the sum and carry-out select fields, a 12-bit seed, and a reseed flag. It applies that configuration to the modulator only at a frame boundary, so the level words never change mid-frame. A reseed request also holds the modulator in reset for a programmable flush interval, so the new seed takes effect from a clean state.

---
 rtl/mash_cfg_ctrl_if.sv | 38 +++
 rtl/mash_cfg_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mash_cfg_ctrl_if.sv
// Configuration request bus for mash_cfg_ctrl.
//
// Carries one complete modulator configuration plus a valid/ready handshake.
// A word transfers on the clock edge where cfg_valid and cfg_ready are both
// high.
//
//   cfg_valid     master -> slave  request present
//   cfg_ready     slave  -> master request can be taken this cycle
//   cfg_level1..3 master -> slave  requested level words (P_DATA_WIDTH each)
//   cfg_sum_sel   master -> slave  requested sum select (8)
//   cfg_cout_sel  master -> slave  requested carry-out select (9)
//   cfg_seed      master -> slave  requested seed (12)
//   cfg_reseed    master -> slave  apply with a modulator flush
interface mash_cfg_ctrl_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [P_DATA_WIDTH-1:0] cfg_level1;
    logic [P_DATA_WIDTH-1:0] cfg_level2;
    logic [P_DATA_WIDTH-1:0] cfg_level3;
    logic [7:0]              cfg_sum_sel;
    logic [8:0]              cfg_cout_sel;
    logic [11:0]             cfg_seed;
    logic                    cfg_reseed;

    modport master (
        output cfg_valid, cfg_level1, cfg_level2, cfg_level3,
               cfg_sum_sel, cfg_cout_sel, cfg_seed, cfg_reseed,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_level1, cfg_level2, cfg_level3,
               cfg_sum_sel, cfg_cout_sel, cfg_seed, cfg_reseed,
        output cfg_ready
    );
endinterface

// File: rtl/mash_cfg_ctrl.sv
// Configuration sequencer for the three-stage MASH delta-sigma modulator.
//
// A request is captured into a shadow register, then copied to the active
// registers at the next frame boundary so level words never change inside a
// frame. A reseed request additionally holds the modulator in reset for
// P_FLUSH_CYCLES cycles so the new seed starts from a clean state. While the
// modulator is disabled every cycle counts as a boundary.
//
// Parameters:
//   P_DATA_WIDTH     width of each level word
//   P_UPDATE_PERIOD  frame length in enabled cycles (>= 2)
//   P_FLUSH_CYCLES   modulator reset length on a reseed apply (>= 1)
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_enable         modulator run enable; frame counter advances only when high
//   cfg              configuration request bus (slave side)
//   o_level1..3      active level words
//   o_sum_sel        active sum select
//   o_cout_sel       active carry-out select
//   o_seed           active seed
//   o_mash_rst_n     registered active-low reset to the modulator
//   o_update_pulse   one-cycle pulse after the active registers change
//   o_busy           a request is pending or a flush is running
module mash_cfg_ctrl #(
    parameter int P_DATA_WIDTH    = 8,
    parameter int P_UPDATE_PERIOD = 16,
    parameter int P_FLUSH_CYCLES  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    mash_cfg_ctrl_if.slave          cfg,
    output logic [P_DATA_WIDTH-1:0] o_level1,
    output logic [P_DATA_WIDTH-1:0] o_level2,
    output logic [P_DATA_WIDTH-1:0] o_level3,
    output logic [7:0]              o_sum_sel,
    output logic [8:0]              o_cout_sel,
    output logic [11:0]             o_seed,
    output logic                    o_mash_rst_n,
    output logic                    o_update_pulse,
    output logic                    o_busy
);

    localparam int FC_W = $clog2(P_UPDATE_PERIOD);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(P_UPDATE_PERIOD - 1);
    localparam int FL_W = (P_FLUSH_CYCLES > 1) ? $clog2(P_FLUSH_CYCLES) : 1;
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(P_FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [P_DATA_WIDTH-1:0] level1;
        logic [P_DATA_WIDTH-1:0] level2;
        logic [P_DATA_WIDTH-1:0] level3;
        logic [7:0]              sum_sel;
        logic [8:0]              cout_sel;
        logic [11:0]             seed;
        logic                    reseed;
    } cfg_t;

    state_t          state;
    logic [FC_W-1:0] fc;
    logic [FL_W-1:0] flush_cnt;
    cfg_t            shadow;
    cfg_t            active;
    cfg_t            cfg_in;

    logic accept;
    logic boundary;
    logic apply;
    logic flush_done;
    logic next_in_flush;

    assign cfg_in = '{
        level1:   cfg.cfg_level1,
        level2:   cfg.cfg_level2,
        level3:   cfg.cfg_level3,
        sum_sel:  cfg.cfg_sum_sel,
        cout_sel: cfg.cfg_cout_sel,
        seed:     cfg.cfg_seed,
        reseed:   cfg.cfg_reseed
    };

    // Ready only in IDLE, so an accept can never coincide with an apply.
    assign cfg.cfg_ready = (state == IDLE);
    assign o_busy        = (state != IDLE);

    assign accept     = cfg.cfg_valid & (state == IDLE);
    // A stopped modulator has no frame to protect, so it is always at a boundary.
    assign boundary   = ~i_enable | (fc == FC_LAST);
    assign apply      = (state == PEND) & boundary;
    assign flush_done = (state == FLUSH) & (flush_cnt == '0);
    // True when the state after this edge is FLUSH; drives the modulator reset.
    assign next_in_flush = (apply & shadow.reseed) | ((state == FLUSH) & ~flush_done);

    assign o_level1   = active.level1;
    assign o_level2   = active.level2;
    assign o_level3   = active.level3;
    assign o_sum_sel  = active.sum_sel;
    assign o_cout_sel = active.cout_sel;
    assign o_seed     = active.seed;

    // NOTE: the configuration registers are ordinary flops, not a RAM, so they
    // all take the reset; this is also what discards a pending shadow word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            fc             <= '0;
            flush_cnt      <= '0;
            shadow         <= '0;
            active         <= '0;
            o_mash_rst_n   <= 1'b0;
            o_update_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every term
            // below sees the pre-edge values of state, fc and shadow.
            o_mash_rst_n   <= i_enable & ~next_in_flush;
            o_update_pulse <= (apply & ~shadow.reseed) | flush_done;

            if (state == FLUSH) begin
                fc <= '0;
            end else if (i_enable) begin
                fc <= (fc == FC_LAST) ? '0 : fc + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        shadow <= cfg_in;
                        state  <= PEND;
                    end
                end
                PEND: begin
                    if (boundary) begin
                        active <= shadow;
                        if (shadow.reseed) begin
                            flush_cnt <= FL_LOAD;
                            state     <= FLUSH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
